dma_dst_ctrl: RTL and testbench

Destination-side channel engine, the store counterpart of the channel's source/load engine. It is started once the current BD has been fetched. It pops packed source bytes from the channel buffer, realigns them to the destination byte offset, and issues single-outstanding word writes on the core store bus. It reports idle/done to the source engine and the channel register file.

---
 rtl/dma_dst_ctrl_if.sv | 33 +++
 rtl/dma_dst_ctrl.sv | 159 +++++++++++++++
 tb/tb_dma_dst_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_dst_ctrl_if.sv
// Destination engine bus bundle: channel buffer pop port plus core store port.
interface dma_dst_ctrl_if #(
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned ADDR_WD = 32
);
  localparam int unsigned BE_WD = DATA_WD / 8;

  logic               buf_rvalid;
  logic [DATA_WD-1:0] buf_rdata;
  logic               buf_rready;

  logic               core_st_req;
  logic               core_st_gnt;
  logic               core_st_we;
  logic [BE_WD-1:0]   core_st_be;
  logic [DATA_WD-1:0] core_st_wdata;
  logic [ADDR_WD-1:0] core_st_addr;
  logic               core_st_rvalid;

  modport master (
    input  buf_rvalid, buf_rdata,
    output buf_rready,
    output core_st_req, core_st_we, core_st_be, core_st_wdata, core_st_addr,
    input  core_st_gnt, core_st_rvalid
  );

  modport slave (
    output buf_rvalid, buf_rdata,
    input  buf_rready,
    input  core_st_req, core_st_we, core_st_be, core_st_wdata, core_st_addr,
    output core_st_gnt, core_st_rvalid
  );
endinterface

// File: rtl/dma_dst_ctrl.sv
// DMA destination engine: realigns packed buffer bytes to the destination offset
// and issues single-outstanding word stores. DMA_DST_PERF_CNT_EN adds a stall counter.
module dma_dst_ctrl #(
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned ADDR_WD = 32,
  parameter int unsigned LEN_WD  = 12,
  parameter int unsigned BE_WD   = DATA_WD / 8
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               dst_start_i,
  input  logic [ADDR_WD-1:0] dst_addr_i,
  input  logic [LEN_WD-1:0]  data_length_i,
  input  logic               bd_last_i,
  input  logic               src_done_i,
  output logic               dst_idle_o,
  output logic               dst_done_o,
  output logic               ch_done_o,
`ifdef DMA_DST_PERF_CNT_EN
  output logic [15:0]        perf_stall_cnt_o,
`endif
  dma_dst_ctrl_if.master     bus
);
  localparam int unsigned CNT_WD = LEN_WD + 1;
  localparam int unsigned SPN_WD = LEN_WD + 2;

  typedef enum logic [2:0] {IDLE, FETCH, REQ, RESP, DONE} state_t;
  state_t state;

  logic [1:0]         off;
  logic [LEN_WD-1:0]  len;
  logic [ADDR_WD-1:0] base;
  logic               bd_last_q;
  logic               src_done_q;
  logic [CNT_WD-1:0]  beat_cnt, word_cnt;
  logic [DATA_WD-1:0] cur, carry;
  logic               st_req_q;
  logic [ADDR_WD-1:0] st_addr_q;
  logic [BE_WD-1:0]   st_be_q;
  logic [DATA_WD-1:0] st_wdata_q;
  logic               done_q, ch_done_q;

  logic [SPN_WD-1:0]  span;
  logic [CNT_WD-1:0]  beats_total, words_total;
  logic               need_pop;
  logic [DATA_WD-1:0] cur_nxt, wdata_nxt;
  logic [BE_WD-1:0]   first_m, last_m, be_nxt;
  logic [ADDR_WD-1:0] addr_nxt;

  assign span        = SPN_WD'(off) + SPN_WD'(len);
  assign beats_total = CNT_WD'((span + SPN_WD'(3)) >> 2);
  assign words_total = CNT_WD'((SPN_WD'(len) + SPN_WD'(3)) >> 2);
  assign need_pop    = word_cnt < words_total;
  assign addr_nxt    = base + ADDR_WD'({beat_cnt, 2'b00});

  // Beat data: current word shifted up by the offset, low lanes filled from the previous word.
  always_comb begin
    cur_nxt   = need_pop ? bus.buf_rdata : '0;
    wdata_nxt = (off == 2'd0) ? cur_nxt
              : (cur_nxt << (8 * 32'(off))) | (carry >> (8 * (BE_WD - 32'(off))));
    first_m   = '0;
    last_m    = '0;
    for (int unsigned i = 0; i < BE_WD; i++) begin
      first_m[i] = (i >= 32'(off)) && (SPN_WD'(i) < span);
      last_m[i]  = (span[1:0] == 2'b00) || (i < 32'(span[1:0]));
    end
    be_nxt = '1;
    if (beat_cnt == '0)                           be_nxt = be_nxt & first_m;
    if (beat_cnt == beats_total - CNT_WD'(1))     be_nxt = be_nxt & last_m;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      off        <= '0;
      len        <= '0;
      base       <= '0;
      bd_last_q  <= 1'b0;
      src_done_q <= 1'b0;
      beat_cnt   <= '0;
      word_cnt   <= '0;
      cur        <= '0;
      carry      <= '0;
      st_req_q   <= 1'b0;
      st_addr_q  <= '0;
      st_be_q    <= '0;
      st_wdata_q <= '0;
      done_q     <= 1'b0;
      ch_done_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      ch_done_q <= 1'b0;
      if (src_done_i) src_done_q <= 1'b1;
      unique case (state)
        IDLE: if (dst_start_i) begin
          off       <= dst_addr_i[1:0];
          len       <= data_length_i;
          base      <= {dst_addr_i[ADDR_WD-1:2], 2'b00};
          bd_last_q <= bd_last_i;
          beat_cnt  <= '0;
          word_cnt  <= '0;
          cur       <= '0;
          carry     <= '0;
          state     <= (data_length_i == '0) ? DONE : FETCH;
        end
        FETCH: if (!need_pop || bus.buf_rvalid) begin
          cur        <= cur_nxt;
          if (need_pop) word_cnt <= word_cnt + CNT_WD'(1);
          st_req_q   <= 1'b1;
          st_addr_q  <= addr_nxt;
          st_be_q    <= be_nxt;
          st_wdata_q <= wdata_nxt;
          state      <= REQ;
        end
        REQ: if (bus.core_st_gnt) begin
          st_req_q <= 1'b0;
          state    <= RESP;
        end
        RESP: if (bus.core_st_rvalid) begin
          carry    <= cur;
          beat_cnt <= beat_cnt + CNT_WD'(1);
          state    <= (beat_cnt + CNT_WD'(1) == beats_total) ? DONE : FETCH;
        end
        // A src_done pulse landing in this same cycle is consumed here, not left sticky.
        DONE: if (src_done_q || src_done_i) begin
          done_q     <= 1'b1;
          ch_done_q  <= bd_last_q;
          src_done_q <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef DMA_DST_PERF_CNT_EN
  logic [15:0] perf_q;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      perf_q <= '0;
    end else if (state == IDLE && dst_start_i) begin
      perf_q <= '0;
    end else if (((state == FETCH && !bus.buf_rvalid) || (state == REQ && !bus.core_st_gnt))
                 && perf_q != '1) begin
      perf_q <= perf_q + 16'd1;
    end
  end
  assign perf_stall_cnt_o = perf_q;
`endif

  assign dst_idle_o        = (state == IDLE);
  assign dst_done_o        = done_q;
  assign ch_done_o         = ch_done_q;
  assign bus.buf_rready    = (state == FETCH) && need_pop;
  assign bus.core_st_req   = st_req_q;
  assign bus.core_st_we    = 1'b1;
  assign bus.core_st_be    = st_be_q;
  assign bus.core_st_wdata = st_wdata_q;
  assign bus.core_st_addr  = st_addr_q;
endmodule

// File: tb/tb_dma_dst_ctrl.sv
// Scoreboard bench for dma_dst_ctrl: byte-level model predicts every store beat.
module tb_dma_dst_ctrl;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        dst_start;
  logic [31:0] dst_addr;
  logic [11:0] data_length;
  logic        bd_last;
  logic        src_done;
  logic        dst_idle, dst_done, ch_done;
`ifdef DMA_DST_PERF_CNT_EN
  logic [15:0] perf_cnt;
`endif

  dma_dst_ctrl_if #(.DATA_WD(32), .ADDR_WD(32)) bus_if ();

  dma_dst_ctrl #(.DATA_WD(32), .ADDR_WD(32), .LEN_WD(12)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .dst_start_i   (dst_start),
    .dst_addr_i    (dst_addr),
    .data_length_i (data_length),
    .bd_last_i     (bd_last),
    .src_done_i    (src_done),
    .dst_idle_o    (dst_idle),
    .dst_done_o    (dst_done),
    .ch_done_o     (ch_done),
`ifdef DMA_DST_PERF_CNT_EN
    .perf_stall_cnt_o (perf_cnt),
`endif
    .bus           (bus_if)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned done_cnt = 0, ch_cnt = 0, done_cyc = 0;
  int unsigned gnt_stall_left = 0, rv_stall_left = 0;
  bit          ack_pend = 0, hold_ack = 0, in_req = 0;
  logic [31:0] hold_addr, hold_data;
  logic [3:0]  hold_be;
  logic [31:0] buf_q[$];
  wr_t         wr_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Buffer and store-bus responder; all decisions taken on the falling edge.
  initial begin
    bus_if.buf_rvalid = 1'b0;
    bus_if.buf_rdata = '0;
    bus_if.core_st_gnt = 1'b0;
    bus_if.core_st_rvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (dst_done) begin done_cnt++; done_cyc = cyc; end
      if (ch_done) ch_cnt++;
      bus_if.core_st_rvalid = 1'b0;
      bus_if.core_st_gnt = 1'b0;
      bus_if.buf_rvalid = 1'b0;
      if (rstn) begin
        if (ack_pend && !hold_ack) begin
          bus_if.core_st_rvalid = 1'b1;
          ack_pend = 0;
        end
        if (bus_if.core_st_req) begin
          if (!in_req) begin
            in_req = 1;
            hold_addr = bus_if.core_st_addr;
            hold_be = bus_if.core_st_be;
            hold_data = bus_if.core_st_wdata;
          end else begin
            check_eq("stall_addr", bus_if.core_st_addr, hold_addr);
            check_eq("stall_be", 32'(bus_if.core_st_be), 32'(hold_be));
            check_eq("stall_wdata", bus_if.core_st_wdata, hold_data);
          end
          if (gnt_stall_left > 0) begin
            gnt_stall_left--;
          end else begin
            bus_if.core_st_gnt = 1'b1;
            in_req = 0;
            ack_pend = 1;
            if (wr_q.size() == 0) begin
              check_eq("spurious_req", 32'(bus_if.core_st_req), 32'd0);
            end else begin
              wr_t e;
              e = wr_q.pop_front();
              check_eq("wr_addr", bus_if.core_st_addr, e.addr);
              check_eq("wr_be", 32'(bus_if.core_st_be), 32'(e.be));
              check_eq("wr_data", bus_if.core_st_wdata, e.data);
            end
          end
        end
        if (buf_q.size() > 0) begin
          if (bus_if.buf_rready && rv_stall_left > 0) begin
            rv_stall_left--;
          end else begin
            bus_if.buf_rvalid = 1'b1;
            bus_if.buf_rdata = buf_q[0];
            if (bus_if.buf_rready) void'(buf_q.pop_front());
          end
        end
      end
    end
  end

  // Byte-level model: byte k of the transfer lands at address addr+k.
  task automatic push_model(input logic [31:0] addr, input int unsigned len,
                            input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] wa, k, src;
    int unsigned nb;
    wr_t e;
    nb = (32'(addr[1:0]) + len + 3) / 4;
    if (len > 0) buf_q.push_back(w0);
    if (len > 4) buf_q.push_back(w1);
    for (int unsigned b = 0; b < nb; b++) begin
      wa = {addr[31:2], 2'b00} + 32'(4 * b);
      e.addr = wa;
      e.be = '0;
      e.data = '0;
      for (int unsigned ln = 0; ln < 4; ln++) begin
        k = wa + ln - addr;
        if (k < len) begin
          src = (k < 4) ? w0 : w1;
          e.be[ln] = 1'b1;
          e.data[8*ln +: 8] = src[8*k[1:0] +: 8];
        end
      end
      wr_q.push_back(e);
    end
  endtask

  // src_mode: 0 = src_done with start, 1 = after all writes, 2 = before start.
  task automatic run_xfer(input logic [31:0] addr, input int unsigned len, input logic last,
                          input logic [31:0] w0, input logic [31:0] w1, input int src_mode,
                          output int unsigned st_cyc);
    int unsigned done0, ch0, n;
    push_model(addr, len, w0, w1);
    done0 = done_cnt;
    ch0 = ch_cnt;
    if (src_mode == 2) begin
      @(negedge clk); src_done = 1'b1;
      @(negedge clk); src_done = 1'b0;
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    dst_start = 1'b1;
    dst_addr = addr;
    data_length = 12'(len);
    bd_last = last;
    st_cyc = cyc;
    if (src_mode == 0) src_done = 1'b1;
    @(negedge clk);
    dst_start = 1'b0;
    src_done = 1'b0;
    n = 0;
    while ((wr_q.size() > 0 || ack_pend) && n < 300) begin @(negedge clk); n++; end
    check_eq("drain_in_time", 32'(n < 300), 32'd1);
    if (src_mode == 1) begin
      repeat (4) @(negedge clk);
      check_eq("no_done_before_src", done_cnt - done0, 32'd0);
      src_done = 1'b1;
      @(negedge clk);
      src_done = 1'b0;
    end
    n = 0;
    while (done_cnt == done0 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check_eq("done_pulses", done_cnt - done0, 32'd1);
    check_eq("ch_done_pulses", ch_cnt - ch0, 32'(last));
    check_eq("buf_left", buf_q.size(), 32'd0);
    check_eq("idle_after", 32'(dst_idle), 32'd1);
  endtask

  initial begin
    int unsigned st, n;
    rstn = 1'b0;
    dst_start = 1'b0;
    dst_addr = '0;
    data_length = '0;
    bd_last = 1'b0;
    src_done = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_idle", 32'(dst_idle), 32'd1);
    check_eq("rst_req", 32'(bus_if.core_st_req), 32'd0);
    check_eq("rst_done", 32'(dst_done), 32'd0);
    check_eq("rst_ch_done", 32'(ch_done), 32'd0);
    check_eq("rst_rready", 32'(bus_if.buf_rready), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(32'h100, 8, 1'b0, 32'h44332211, 32'h88776655, 1, st);
    run_xfer(32'h103, 6, 1'b1, 32'h44332211, 32'h00006655, 0, st);
    run_xfer(32'h101, 2, 1'b0, 32'h0000BBAA, 32'h0, 0, st);
    run_xfer(32'hFFFF_FFFE, 4, 1'b0, 32'hD4C3B2A1, 32'h0, 2, st);

    run_xfer(32'h180, 0, 1'b1, 32'h0, 32'h0, 2, st);
    check_eq("len0_done_latency", done_cyc - st, 32'd2);

    gnt_stall_left = 5;
    rv_stall_left = 3;
    fork
      run_xfer(32'h200, 4, 1'b0, 32'hCAFEF00D, 32'h0, 0, st);
      begin
        repeat (6) @(negedge clk);
        dst_start = 1'b1;
        dst_addr = 32'h400;
        data_length = 12'd0;
        @(negedge clk);
        dst_start = 1'b0;
      end
    join
`ifdef DMA_DST_PERF_CNT_EN
    check_eq("perf_stall", 32'(perf_cnt), 32'd8);
`endif

    hold_ack = 1;
    push_model(32'h300, 4, 32'h0BADBEEF, 32'h0);
    @(negedge clk);
    dst_start = 1'b1;
    dst_addr = 32'h300;
    data_length = 12'd4;
    @(negedge clk);
    dst_start = 1'b0;
    n = 0;
    while (!ack_pend && n < 50) begin @(negedge clk); n++; end
    check_eq("reach_resp", 32'(ack_pend), 32'd1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check_eq("rst_mid_idle", 32'(dst_idle), 32'd1);
    check_eq("rst_mid_req", 32'(bus_if.core_st_req), 32'd0);
    @(negedge clk);
    ack_pend = 0;
    hold_ack = 0;
    buf_q.delete();
    wr_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("post_rst_no_req", 32'(bus_if.core_st_req), 32'd0);
    run_xfer(32'h105, 3, 1'b1, 32'h00CCBBAA, 32'h0, 0, st);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
